mmio_responder: RTL and testbench

//  Memory-mapped slave on the CPU data-memory channel. It answers loads and stores that
//  the outer address decode routes into a 32-byte window at BASE_ADDR.
//  It provides: a DONE/scratch register, an LED output register, a free-running 64-bit

---
 rtl/mmio_responder_if.sv | 24 ++
 rtl/mmio_responder.sv | 114 +++++++++++
 tb/tb_mmio_responder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_responder_if.sv
// mmio_responder_if: CPU data-memory channel bundle (load request/response and store request).
interface mmio_responder_if #(parameter int LDTAG_W = 4);
   logic               ld_valid;
   logic               ld_ready;
   logic [31:0]        ld_addr;
   logic [LDTAG_W-1:0] ld_tag;
   logic               ld_resp_valid;
   logic               ld_resp_ready;
   logic [63:0]        ld_resp_data;
   logic [LDTAG_W-1:0] ld_resp_tag;
   logic               st_valid;
   logic               st_ready;
   logic [31:0]        st_addr;
   logic [63:0]        st_wdata;
   logic [7:0]         st_wstrb;
   modport master (
      output ld_valid, ld_addr, ld_tag, ld_resp_ready, st_valid, st_addr, st_wdata, st_wstrb,
      input  ld_ready, ld_resp_valid, ld_resp_data, ld_resp_tag, st_ready
   );
   modport slave (
      input  ld_valid, ld_addr, ld_tag, ld_resp_ready, st_valid, st_addr, st_wdata, st_wstrb,
      output ld_ready, ld_resp_valid, ld_resp_data, ld_resp_tag, st_ready
   );
endinterface

// File: rtl/mmio_responder.sv
// mmio_responder: MMIO slave with DONE/LED/CYCLE/INPUT slots, fixed-latency load pipe and credit-limited response FIFO.
module mmio_responder #(
   parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
   parameter int          LDTAG_W         = 4,
   parameter int          LD_LATENCY      = 2,
   parameter int          RESP_FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mmio_responder_if.slave      bus,
   input  logic [3:0]           sw,
   input  logic [3:0]           btn,
   output logic [3:0]           led_o,
   output logic                 done_o,
   output logic [63:0]          done_val_o
);
   localparam int AW = RESP_FIFO_DEPTH > 1 ? $clog2(RESP_FIFO_DEPTH) : 1;
   localparam int CW = $clog2(RESP_FIFO_DEPTH + LD_LATENCY + 1);
   logic [3:0]         sw_m, sw_s, btn_m, btn_s;
   logic [63:0]        cycle, rd_data;
   logic               ld_fire, st_fire, pop;
   logic               push_v;
   logic [63:0]        push_d;
   logic [LDTAG_W-1:0] push_t;
   logic [CW-1:0]      inflight, cnt;
   logic [AW-1:0]      wp, rp;
   logic [63:0]        mem_d [RESP_FIFO_DEPTH];
   logic [LDTAG_W-1:0] mem_t [RESP_FIFO_DEPTH];
   logic               unused;
   assign unused = ^{bus.ld_addr[31:5], bus.ld_addr[2:0], bus.st_addr[31:5], bus.st_addr[2:0], BASE_ADDR};
   assign bus.st_ready = rst_n;
   // Credits count both queued and in-flight loads so the FIFO can never overflow.
   assign bus.ld_ready = rst_n & (cnt + inflight < CW'(RESP_FIFO_DEPTH));
   assign ld_fire = bus.ld_valid & bus.ld_ready;
   assign st_fire = bus.st_valid & rst_n;
   assign pop = bus.ld_resp_valid & bus.ld_resp_ready;
   assign bus.ld_resp_valid = cnt != '0;
   assign bus.ld_resp_data = bus.ld_resp_valid ? mem_d[rp] : '0;
   assign bus.ld_resp_tag = bus.ld_resp_valid ? mem_t[rp] : '0;
   assign rd_data = bus.ld_addr[4:3] == 2'd0 ? done_val_o :
                    bus.ld_addr[4:3] == 2'd1 ? {60'b0, led_o} :
                    bus.ld_addr[4:3] == 2'd2 ? cycle : {56'b0, btn_s, sw_s};
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw_m       <= '0;
         sw_s       <= '0;
         btn_m      <= '0;
         btn_s      <= '0;
         cycle      <= '0;
         led_o      <= '0;
         done_o     <= 1'b0;
         done_val_o <= '0;
      end else begin
         sw_m  <= sw;
         sw_s  <= sw_m;
         btn_m <= btn;
         btn_s <= btn_m;
         cycle <= cycle + 64'd1;
         if (st_fire && bus.st_addr[4:3] == 2'd0) begin
            for (int i = 0; i < 8; i++)
               if (bus.st_wstrb[i]) done_val_o[8*i +: 8] <= bus.st_wdata[8*i +: 8];
            if (|bus.st_wstrb) done_o <= 1'b1;
         end
         if (st_fire && bus.st_addr[4:3] == 2'd1 && bus.st_wstrb[0]) led_o <= bus.st_wdata[3:0];
      end
   end
   // The FIFO write is the last latency stage, so only LD_LATENCY-1 pipe registers exist.
   if (LD_LATENCY == 1) begin : g_nopipe
      assign push_v   = ld_fire;
      assign push_d   = rd_data;
      assign push_t   = bus.ld_tag;
      assign inflight = '0;
   end else begin : g_pipe
      logic               p_v [LD_LATENCY-1];
      logic [63:0]        p_d [LD_LATENCY-1];
      logic [LDTAG_W-1:0] p_t [LD_LATENCY-1];
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int i = 0; i < LD_LATENCY - 1; i++) p_v[i] <= 1'b0;
         end else begin
            p_v[0] <= ld_fire;
            for (int i = 1; i < LD_LATENCY - 1; i++) p_v[i] <= p_v[i-1];
         end
         p_d[0] <= rd_data;
         p_t[0] <= bus.ld_tag;
         for (int i = 1; i < LD_LATENCY - 1; i++) begin
            p_d[i] <= p_d[i-1];
            p_t[i] <= p_t[i-1];
         end
      end
      always_comb begin
         inflight = '0;
         for (int i = 0; i < LD_LATENCY - 1; i++) inflight = inflight + CW'(p_v[i]);
      end
      assign push_v = p_v[LD_LATENCY-2];
      assign push_d = p_d[LD_LATENCY-2];
      assign push_t = p_t[LD_LATENCY-2];
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push_v) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         cnt <= cnt + CW'(push_v) - CW'(pop);
      end
      if (push_v) begin
         mem_d[wp] <= push_d;
         mem_t[wp] <= push_t;
      end
   end
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: scenario tasks with a load-response scoreboard queue.
module tb_mmio_responder;
   localparam int          LAT   = 2;
   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   typedef struct {
      logic [3:0]  t;
      logic [63:0] d;
      bit          chk_d;
      int          ta;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  sw = '0, btn = '0, led_o;
   logic        done_o;
   logic [63:0] done_val_o;
   int          n_cmp = 0, n_err = 0, cyc = 0;
   exp_t        exp_q[$];
   logic [63:0] got_q[$];
   logic [63:0] m_done = '0;
   logic [3:0]  m_led = '0;
   mmio_responder_if #(.LDTAG_W(4)) bus ();
   mmio_responder #(.BASE_ADDR(BASE), .LDTAG_W(4), .LD_LATENCY(LAT), .RESP_FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .sw(sw), .btn(btn),
      .led_o(led_o), .done_o(done_o), .done_val_o(done_val_o)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
      bus.st_valid = 1'b1;
      bus.st_addr  = a;
      bus.st_wdata = d;
      bus.st_wstrb = s;
      n_cmp++;
      if (bus.st_ready !== 1'b1) begin n_err++; $display("FAIL st_ready got=%b exp=1", bus.st_ready); end
      if (a[4:3] == 2'd0) for (int i = 0; i < 8; i++) if (s[i]) m_done[8*i +: 8] = d[8*i +: 8];
      if (a[4:3] == 2'd1 && s[0]) m_led = d[3:0];
      step();
      bus.st_valid = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [3:0] tag, input logic [63:0] e, input bit chk_d);
      int budget = 50;
      bus.ld_valid = 1'b1;
      bus.ld_addr  = a;
      bus.ld_tag   = tag;
      while (!bus.ld_ready && budget > 0) begin step(); budget--; end
      if (!bus.ld_ready) begin n_cmp++; n_err++; $display("FAIL load_accept_timeout tag=%0h", tag); end
      else exp_q.push_back('{tag, e, chk_d, cyc});
      step();
      bus.ld_valid = 1'b0;
   endtask

   task automatic collect(input int n, input bit chk_lat);
      int   got = 0, budget = 200;
      exp_t e;
      bus.ld_resp_ready = 1'b1;
      while (got < n && budget > 0) begin
         if (bus.ld_resp_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL resp_unexpected got tag=%0h data=%h exp=none", bus.ld_resp_tag, bus.ld_resp_data);
            end else begin
               e = exp_q.pop_front();
               if (bus.ld_resp_tag !== e.t || (e.chk_d && bus.ld_resp_data !== e.d)) begin
                  n_err++;
                  $display("FAIL resp got tag=%0h data=%h exp tag=%0h data=%h", bus.ld_resp_tag, bus.ld_resp_data, e.t, e.d);
               end
               if (chk_lat) begin
                  n_cmp++;
                  if (cyc - e.ta !== LAT) begin n_err++; $display("FAIL resp_latency tag=%0h got=%0d exp=%0d", e.t, cyc - e.ta, LAT); end
               end
            end
            got_q.push_back(bus.ld_resp_data);
            got++;
         end
         step();
         budget--;
      end
      if (got < n) begin n_cmp++; n_err++; $display("FAIL resp_timeout got=%0d exp=%0d", got, n); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      n_cmp++;
      if ({bus.ld_resp_valid, bus.ld_ready, bus.st_ready, led_o, done_o} !== 8'h0 ||
          bus.ld_resp_data !== 64'h0 || bus.ld_resp_tag !== 4'h0 || done_val_o !== 64'h0) begin
         n_err++;
         $display("FAIL reset_values got rv=%b lr=%b sr=%b led=%h done=%b dv=%h rd=%h rt=%h exp all zero",
                  bus.ld_resp_valid, bus.ld_ready, bus.st_ready, led_o, done_o, done_val_o, bus.ld_resp_data, bus.ld_resp_tag);
      end
      rst_n = 1'b1;
      step();
      n_cmp++;
      if (bus.ld_ready !== 1'b1 || bus.st_ready !== 1'b1) begin
         n_err++;
         $display("FAIL ready_after_reset got ld=%b st=%b exp 1 1", bus.ld_ready, bus.st_ready);
      end
   endtask

   task automatic test_done_store();
      do_store(BASE, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
      n_cmp++;
      if (done_o !== 1'b0 || done_val_o !== 64'h0) begin
         n_err++;
         $display("FAIL done_zero_strobe got done=%b dv=%h exp 0 0", done_o, done_val_o);
      end
      do_store(BASE + 32'd2, 64'h0000_0000_CAFE_F00D, 8'h0F);
      n_cmp++;
      if (done_o !== 1'b1 || done_val_o !== 64'h0000_0000_CAFE_F00D) begin
         n_err++;
         $display("FAIL done_store got done=%b dv=%h exp 1 0000_0000_cafe_f00d", done_o, done_val_o);
      end
   endtask

   task automatic test_led_load();
      do_store(BASE + 32'd8, 64'h5, 8'h01);
      do_store(BASE + 32'd8, 64'hF, 8'hFE);
      n_cmp++;
      if (led_o !== 4'h5) begin n_err++; $display("FAIL led_store got=%h exp=5", led_o); end
      do_load(BASE + 32'd8, 4'd3, 64'h5, 1'b1);
      collect(1, 1'b1);
   endtask

   task automatic test_same_cycle();
      do_store(BASE, 64'h0, 8'hFF);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = BASE;
      bus.ld_tag   = 4'd5;
      bus.st_valid = 1'b1;
      bus.st_addr  = BASE + 32'd4;
      bus.st_wdata = 64'h1234_5678;
      bus.st_wstrb = 8'hFF;
      n_cmp++;
      if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL same_cycle_ld_ready got=%b exp=1", bus.ld_ready); end
      exp_q.push_back('{4'd5, m_done, 1'b1, cyc});
      m_done = 64'h1234_5678;
      step();
      bus.ld_valid = 1'b0;
      bus.st_valid = 1'b0;
      do_load(BASE, 4'd6, m_done, 1'b1);
      collect(2, 1'b1);
   endtask

   task automatic test_inputs();
      sw  = 4'hA;
      btn = 4'h3;
      repeat (3) step();
      do_store(BASE + 32'd24, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      do_store(BASE + 32'd16, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      n_cmp++;
      if (done_val_o !== m_done || led_o !== m_led) begin
         n_err++;
         $display("FAIL ro_write_discard got dv=%h led=%h exp dv=%h led=%h", done_val_o, led_o, m_done, m_led);
      end
      do_load(BASE + 32'd29, 4'd7, 64'h3A, 1'b1);
      collect(1, 1'b1);
   endtask

   task automatic test_back_to_back();
      int          acc = 0;
      logic [63:0] d0;
      logic [3:0]  t0;
      bus.ld_resp_ready = 1'b0;
      bus.ld_valid = 1'b1;
      bus.ld_addr  = BASE;
      for (int k = 0; k < 12; k++) begin
         bus.ld_tag = 4'(8 + acc);
         if (bus.ld_ready) begin exp_q.push_back('{4'(8 + acc), m_done, 1'b1, cyc}); acc++; end
         step();
      end
      bus.ld_valid = 1'b0;
      n_cmp++;
      if (acc !== DEPTH || bus.ld_ready !== 1'b0) begin
         n_err++;
         $display("FAIL backpressure_accepts got acc=%0d ld_ready=%b exp acc=%0d ld_ready=0", acc, bus.ld_ready, DEPTH);
      end
      d0 = bus.ld_resp_data;
      t0 = bus.ld_resp_tag;
      step();
      n_cmp++;
      if (bus.ld_resp_valid !== 1'b1 || bus.ld_resp_data !== d0 || bus.ld_resp_tag !== t0 || t0 !== 4'd8) begin
         n_err++;
         $display("FAIL stall_hold got v=%b tag=%0h data=%h exp v=1 tag=8 data=%h", bus.ld_resp_valid, bus.ld_resp_tag, bus.ld_resp_data, d0);
      end
      collect(DEPTH, 1'b0);
      n_cmp++;
      if (exp_q.size() != 0 || bus.ld_resp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL drain_empty got left=%0d valid=%b exp 0 0", exp_q.size(), bus.ld_resp_valid);
      end
   endtask

   task automatic test_cycle_delta();
      int ta, tb;
      got_q.delete();
      bus.ld_resp_ready = 1'b0;
      do_load(BASE + 32'd16, 4'd1, 64'h0, 1'b0);
      ta = exp_q[exp_q.size()-1].ta;
      repeat (6) step();
      do_load(BASE + 32'd17, 4'd2, 64'h0, 1'b0);
      tb = exp_q[exp_q.size()-1].ta;
      collect(2, 1'b0);
      n_cmp++;
      if (got_q.size() != 2) begin
         n_err++;
         $display("FAIL cycle_delta got responses=%0d exp=2", got_q.size());
      end else if (got_q[1] - got_q[0] !== 64'(tb - ta)) begin
         n_err++;
         $display("FAIL cycle_delta got=%0d exp=%0d", got_q[1] - got_q[0], tb - ta);
      end
   endtask

   task automatic test_reset_midop();
      int stale = 0;
      bus.ld_resp_ready = 1'b0;
      for (int k = 1; k <= 3; k++) do_load(BASE, 4'(k), m_done, 1'b1);
      repeat (3) step();
      n_cmp++;
      if (bus.ld_resp_valid !== 1'b1) begin n_err++; $display("FAIL queued_before_reset got valid=%b exp=1", bus.ld_resp_valid); end
      rst_n = 1'b0;
      step();
      n_cmp++;
      if (bus.ld_resp_valid !== 1'b0 || bus.ld_ready !== 1'b0 || bus.st_ready !== 1'b0 ||
          led_o !== 4'h0 || done_o !== 1'b0 || done_val_o !== 64'h0 || bus.ld_resp_data !== 64'h0) begin
         n_err++;
         $display("FAIL midop_reset got rv=%b lr=%b sr=%b led=%h done=%b dv=%h rd=%h exp all zero",
                  bus.ld_resp_valid, bus.ld_ready, bus.st_ready, led_o, done_o, done_val_o, bus.ld_resp_data);
      end
      exp_q.delete();
      m_done = '0;
      m_led  = '0;
      step();
      rst_n = 1'b1;
      bus.ld_resp_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (bus.ld_resp_valid) stale++;
         step();
      end
      n_cmp++;
      if (stale !== 0 || led_o !== 4'h0 || done_o !== 1'b0) begin
         n_err++;
         $display("FAIL after_reset got stale=%0d led=%h done=%b exp 0 0 0", stale, led_o, done_o);
      end
      do_load(BASE + 32'd8, 4'd4, 64'h0, 1'b1);
      collect(1, 1'b1);
   endtask

   initial begin
      bus.ld_valid = 1'b0;
      bus.ld_addr  = '0;
      bus.ld_tag   = '0;
      bus.ld_resp_ready = 1'b1;
      bus.st_valid = 1'b0;
      bus.st_addr  = '0;
      bus.st_wdata = '0;
      bus.st_wstrb = '0;
      test_reset();
      test_done_store();
      test_led_load();
      test_same_cycle();
      test_inputs();
      test_back_to_back();
      test_cycle_delta();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
